// File: rtl/cordic_hyp_sched_if.sv
// cordic_hyp_sched_if: requester, result and core-side signals of the CORDIC scheduler; slave = scheduler, master = clients/core
interface cordic_hyp_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [4*N_REQ-1:0] req_func;
  logic [16*N_REQ-1:0] req_x;
  logic [16*N_REQ-1:0] req_y;
  logic [N_REQ-1:0] gnt;
  logic out_valid;
  logic [2:0] out_id;
  logic signed [31:0] out_result;
  logic core_st;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic [3:0] core_func;
  logic signed [31:0] core_result;
  modport slave (
    input req, req_func, req_x, req_y, core_result,
    output gnt, out_valid, out_id, out_result, core_st, core_x, core_y, core_func
  );
  modport master (
    output req, req_func, req_x, req_y, core_result,
    input gnt, out_valid, out_id, out_result, core_st, core_x, core_y, core_func
  );
endinterface

// File: rtl/cordic_hyp_sched.sv
// cordic_hyp_sched: round-robin scheduler sharing one hyperbolic CORDIC core (clk, rst, bus: requests in, grants/results/core drive out)
module cordic_hyp_sched #(
  parameter int N_REQ = 4,
  parameter int LATENCY = 16
) (
  input logic clk,
  input logic rst,
  cordic_hyp_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] pick;
  logic [15:0] cnt;
  logic [7:0] req_pad;
  logic [31:0] func_pad;
  logic [127:0] x_pad;
  logic [127:0] y_pad;
  logic [3:0] f_w;
  logic [15:0] x_w;
  logic [15:0] y_w;
  logic ln_w;
  assign req_pad = 8'(bus.req);
  assign func_pad = 32'(bus.req_func);
  assign x_pad = 128'(bus.req_x);
  assign y_pad = 128'(bus.req_y);
  assign f_w = func_pad[{pick, 2'b00} +: 4];
  assign x_w = x_pad[{pick, 4'b0000} +: 16];
  assign y_w = y_pad[{pick, 4'b0000} +: 16];
  assign ln_w = f_w == 4'd8;
  // descending scan so the requester closest above ptr is the last to win
  always_comb begin
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_pad[3'((int'(ptr) + k) % N_REQ)]) pick = 3'((int'(ptr) + k) % N_REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      bus.gnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out_id <= '0;
      bus.out_result <= '0;
      bus.core_st <= 1'b0;
      bus.core_x <= '0;
      bus.core_y <= '0;
      bus.core_func <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          win <= pick;
          bus.gnt <= N_REQ'(8'd1 << pick);
          bus.core_st <= 1'b1;
          bus.core_func <= f_w;
          // ln(x) runs as atanh-style on (x+1, x-1) in Q2.14
          bus.core_x <= ln_w ? x_w + 16'h4000 : x_w;
          bus.core_y <= ln_w ? x_w - 16'h4000 : y_w;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.gnt <= '0;
          bus.core_st <= 1'b0;
          cnt <= 16'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          bus.out_result <= (bus.core_func == 4'd8) ? {bus.core_result[30:0], 1'b0} : bus.core_result;
          bus.out_id <= win;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end else cnt <= cnt - 16'd1;
        DONE: begin
          bus.out_valid <= 1'b0;
          ptr <= (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_hyp_sched.sv
// tb_cordic_hyp_sched: scoreboard bench for cordic_hyp_sched with a fixed-latency core model
module tb_cordic_hyp_sched;
  localparam int N = 4;
  localparam int L = 16;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  typedef struct packed {logic [2:0] id; logic [31:0] res;} exp_t;
  logic clk;
  logic rst;
  cordic_hyp_sched_if #(.N_REQ(N)) bif ();
  cordic_hyp_sched #(.N_REQ(N), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bif));
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic force_en = 1'b0;
  logic [31:0] force_val = '0;
  logic [31:0] m_r = '0;
  int m_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] core_fn(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
    return {x, y ^ {f, 12'h000}};
  endfunction

  function automatic logic [31:0] exp_res(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] cx;
    logic [15:0] cy;
    logic [31:0] r;
    cx = (f == 4'd8) ? x + 16'h4000 : x;
    cy = (f == 4'd8) ? x - 16'h4000 : y;
    r = core_fn(cx, cy, f);
    return (f == 4'd8) ? {r[30:0], 1'b0} : r;
  endfunction

  // core model: result valid only in the single cycle LATENCY cycles after core_st
  always @(posedge clk) begin
    if (bif.core_st === 1'b1) begin
      m_cnt <= L - 1;
      m_r <= force_en ? force_val : core_fn(bif.core_x, bif.core_y, bif.core_func);
      bif.core_result <= JUNK;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      bif.core_result <= (m_cnt == 1) ? m_r : JUNK;
    end else bif.core_result <= JUNK;
  end

  always @(negedge clk) begin
    if (bif.out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: got id=%0d result=%h, required no strobe", bif.out_id, bif.out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bif.out_id !== e.id || bif.out_result !== e.res) begin
          n_bad++;
          $display("FAIL result: got id=%0d result=%h, required id=%0d result=%h", bif.out_id, bif.out_result, e.id, e.res);
        end
      end
    end
  end

  task automatic drive(input int i, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    bif.req[i] = 1'b1;
    bif.req_func[4*i +: 4] = f;
    bif.req_x[16*i +: 16] = x;
    bif.req_y[16*i +: 16] = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.req = '0;
    bif.req_func = '0;
    bif.req_x = '0;
    bif.req_y = '0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (bif.gnt !== 4'b0 || bif.core_st !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gnt_st: got gnt=%b st=%b, required 0/0", bif.gnt, bif.core_st);
    end
    if (bif.out_valid !== 1'b0 || bif.out_id !== 3'd0 || bif.out_result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b id=%0d r=%h, required 0", bif.out_valid, bif.out_id, bif.out_result);
    end
    if (bif.core_x !== 16'd0 || bif.core_y !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_core_xy: got %h/%h, required 0/0", bif.core_x, bif.core_y);
    end
    if (bif.core_func !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_core_func: got %h, required 0", bif.core_func);
    end
    rst = 1'b0;
  endtask

  task automatic test_ln();
    int st_cnt = 1;
    bit got = 0;
    drive(2, 4'd8, 16'h6000, 16'h1111);
    force_en = 1'b1;
    force_val = 32'h0000_0CF6;
    exp_q.push_back('{id: 3'd2, res: 32'h0000_19EC});
    @(negedge clk);
    n_cmp += 3;
    if (bif.gnt !== 4'b0100 || bif.core_st !== 1'b1) begin
      n_bad++;
      $display("FAIL ln_gnt: got gnt=%b st=%b, required 0100/1", bif.gnt, bif.core_st);
    end
    if (bif.core_x !== 16'hA000 || bif.core_y !== 16'h2000) begin
      n_bad++;
      $display("FAIL ln_core_xy: got %h/%h, required a000/2000", bif.core_x, bif.core_y);
    end
    if (bif.core_func !== 4'd8) begin
      n_bad++;
      $display("FAIL ln_core_func: got %h, required 8", bif.core_func);
    end
    bif.req = '0;
    for (int c = 2; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (bif.core_st === 1'b1) st_cnt++;
      if (bif.out_valid === 1'b1) begin
        got = 1;
        n_cmp++;
        if (c != L + 2) begin
          n_bad++;
          $display("FAIL ln_valid_cycle: got %0d, required %0d", c, L + 2);
        end
      end
    end
    force_en = 1'b0;
    n_cmp += 2;
    if (!got) begin
      n_bad++;
      $display("FAIL ln_timeout: got no out_valid, required one");
    end
    if (st_cnt != 1) begin
      n_bad++;
      $display("FAIL ln_st_pulses: got %0d, required 1", st_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_pass();
    bit got = 0;
    drive(0, 4'd3, 16'h1234, 16'h0F00);
    exp_q.push_back('{id: 3'd0, res: exp_res(4'd3, 16'h1234, 16'h0F00)});
    @(negedge clk);
    n_cmp += 2;
    if (bif.gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL pass_gnt: got %b, required 0001", bif.gnt);
    end
    if (bif.core_x !== 16'h1234 || bif.core_y !== 16'h0F00 || bif.core_func !== 4'd3) begin
      n_bad++;
      $display("FAIL pass_core: got %h/%h/%h, required 1234/0f00/3", bif.core_x, bif.core_y, bif.core_func);
    end
    bif.req = '0;
    for (int c = 2; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (bif.out_valid === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL pass_timeout: got no out_valid, required one");
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [3:0] ff[N] = '{4'd8, 4'd3, 4'd5, 4'd1};
    logic [15:0] fx[N] = '{16'h0100, 16'h1357, 16'h2468, 16'h7FFF};
    logic [15:0] fy[N] = '{16'h0000, 16'hAAAA, 16'h5555, 16'h8001};
    int k = 0;
    int last = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) drive(i, ff[i], fx[i], fy[i]);
    for (int j = 0; j < 8; j++) exp_q.push_back('{id: 3'(j % N), res: exp_res(ff[j % N], fx[j % N], fy[j % N])});
    for (int c = 1; c <= 8 * (L + 3) + 10 && k < 8; c++) begin
      @(negedge clk);
      if (bif.gnt !== 4'b0) begin
        n_cmp++;
        if (bif.gnt !== 4'(1 << (k % N))) begin
          n_bad++;
          $display("FAIL fair_gnt_%0d: got %b, required %b", k, bif.gnt, 4'(1 << (k % N)));
        end
        if (k > 0) begin
          n_cmp++;
          if (c - last != L + 3) begin
            n_bad++;
            $display("FAIL fair_spacing_%0d: got %0d, required %0d", k, c - last, L + 3);
          end
        end
        last = c;
        k++;
        if (k == 8) bif.req = '0;
      end
    end
    n_cmp++;
    if (k != 8) begin
      n_bad++;
      $display("FAIL fair_timeout: got %0d grants, required 8", k);
    end
    bif.req = '0;
    repeat (L + 2) @(negedge clk);
  endtask

  task automatic test_late();
    logic [15:0] cx;
    bit got = 0;
    int g = 0;
    drive(1, 4'd5, 16'h2222, 16'h3333);
    exp_q.push_back('{id: 3'd1, res: exp_res(4'd5, 16'h2222, 16'h3333)});
    @(negedge clk);
    n_cmp++;
    if (bif.gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL late_gnt1: got %b, required 0010", bif.gnt);
    end
    cx = bif.core_x;
    bif.req = '0;
    for (int c = 2; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == 5) begin
        drive(3, 4'd8, 16'h0800, 16'hFFFF);
        exp_q.push_back('{id: 3'd3, res: exp_res(4'd8, 16'h0800, 16'hFFFF)});
      end
      n_cmp += 2;
      if (bif.gnt !== 4'b0) begin
        n_bad++;
        $display("FAIL late_early_gnt: got %b at cycle %0d, required 0000", bif.gnt, c);
      end
      if (bif.core_x !== cx) begin
        n_bad++;
        $display("FAIL late_core_x: got %h at cycle %0d, required %h", bif.core_x, c, cx);
      end
      if (bif.out_valid === 1'b1) got = 1;
    end
    for (int c = 1; c <= 10 && g == 0; c++) begin
      @(negedge clk);
      if (bif.gnt !== 4'b0) begin
        g = c;
        n_cmp++;
        if (bif.gnt !== 4'b1000 || c != 2) begin
          n_bad++;
          $display("FAIL late_gnt3: got %b after %0d cycles, required 1000 after 2", bif.gnt, c);
        end
      end
    end
    n_cmp++;
    if (!got || g == 0) begin
      n_bad++;
      $display("FAIL late_timeout: got valid=%0d gnt3=%0d, required both", got, g);
    end
    bif.req = '0;
    repeat (L + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int g = 0;
    drive(1, 4'd2, 16'h0F0F, 16'h00FF);
    exp_q.push_back('{id: 3'd1, res: exp_res(4'd2, 16'h0F0F, 16'h00FF)});
    @(negedge clk);
    bif.req = '0;
    repeat (L + 2) @(negedge clk);
    drive(2, 4'd3, 16'h4444, 16'h5555);
    @(negedge clk);
    n_cmp++;
    if (bif.gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL rmid_gnt: got %b, required 0100", bif.gnt);
    end
    bif.req = '0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 2;
    if (bif.gnt !== 4'b0 || bif.core_st !== 1'b0 || bif.out_valid !== 1'b0 || bif.out_id !== 3'd0) begin
      n_bad++;
      $display("FAIL rmid_ctrl: got gnt=%b st=%b v=%b id=%0d, required 0", bif.gnt, bif.core_st, bif.out_valid, bif.out_id);
    end
    if (bif.out_result !== 32'd0 || bif.core_x !== 16'd0 || bif.core_y !== 16'd0 || bif.core_func !== 4'd0) begin
      n_bad++;
      $display("FAIL rmid_data: got r=%h cx=%h cy=%h cf=%h, required 0", bif.out_result, bif.core_x, bif.core_y, bif.core_func);
    end
    repeat (L + 6) begin
      @(negedge clk);
      if (bif.out_valid === 1'b1 || bif.gnt !== 4'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL rmid_aborted_activity: got activity after reset, required none");
    end
    drive(1, 4'd4, 16'h1111, 16'h2222);
    drive(3, 4'd6, 16'h3333, 16'h4444);
    exp_q.push_back('{id: 3'd1, res: exp_res(4'd4, 16'h1111, 16'h2222)});
    exp_q.push_back('{id: 3'd3, res: exp_res(4'd6, 16'h3333, 16'h4444)});
    @(negedge clk);
    n_cmp++;
    if (bif.gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL rmid_first_gnt: got %b, required 0010", bif.gnt);
    end
    bif.req[1] = 1'b0;
    for (int c = 2; c <= 2 * (L + 3) && g == 0; c++) begin
      @(negedge clk);
      if (bif.gnt !== 4'b0) begin
        g = c;
        n_cmp++;
        if (bif.gnt !== 4'b1000) begin
          n_bad++;
          $display("FAIL rmid_second_gnt: got %b, required 1000", bif.gnt);
        end
      end
    end
    n_cmp++;
    if (g == 0) begin
      n_bad++;
      $display("FAIL rmid_timeout: got no second grant, required 1000");
    end
    bif.req = '0;
    repeat (L + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ln();
    test_pass();
    test_fairness();
    test_late();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cordic_hyp_sched.md
# cordic_hyp_sched

Round-robin scheduler sharing one hyperbolic-mode CORDIC core (`arctan_h`-style: `st` start pulse, `x`/`y` operands, 4-bit `func` select, 32-bit signed result) between `N_REQ` requesters. It arbitrates, latches the winner's operands, and applies the ln pre/post transform for `func == 8`. It pulses the core start, counts the core's fixed iteration latency, and returns the tagged result. It sits between the function-level clients and the single CORDIC datapath instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LATENCY`, 16: core cycles from the `core_st` cycle to a valid `core_result` (≥ 1).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  `N_REQ`: per-requester request level.
- `req_func`  in  `4*N_REQ`: function select, requester i at bits [4i+3:4i].
- `req_x`  in  `16*N_REQ`: x operand, Q2.14, slice i.
- `req_y`  in  `16*N_REQ`: y operand, Q2.14, slice i (ignored for `func == 8`).
- `gnt`  out  `N_REQ`: one-hot, one-cycle grant; operands were consumed.
- `out_valid`  out  1: one-cycle result strobe.
- `out_id`  out  3: index of the requester owning `out_result`.
- `out_result`  out  32 signed: final result.
- `core_st`  out  1: one-cycle start pulse to the core.
- `core_x`, `core_y`  out  16: core operands, held stable from ISSUE through CAPTURE.
- `core_func`  out  4: core function select, held with the operands.
- `core_result`  in  32 signed: core output.

## Operation
- **States:** IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE:**
  - If `req` ≠ 0, pick the winner by round-robin, searching from `ptr` upward and wrapping.
  - Latch the winner's func, x and y, plus its index, then go to ISSUE.
  - If `req` = 0, stay in IDLE.
- **Operand transform, `func == 8` (ln):**
  - `core_x = x + 16'h4000` and `core_y = x - 16'h4000`, both modulo 2^16.
  - The 16'h4000 constant is 1.0 in Q2.14.
- **Operand transform, other `func`:** `core_x = x`, `core_y = y`, passed through unchanged.
- **ISSUE:**
  - `core_st` = 1.
  - `gnt[winner]` = 1.
  - Load the counter with `LATENCY-1`, then go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter = 0, register the result and go to DONE.
  - Result register for `func == 8`: `{core_result[30:0],1'b0}` (×2, bit 31 dropped).
  - Result register for other `func`: `core_result`.
- **DONE:**
  - `out_valid` = 1, with `out_id` and `out_result` valid.
  - `ptr` ← winner + 1, modulo `N_REQ`.
  - Go to IDLE.
- **Requester protocol:**
  - Hold `req` and the operands until `gnt`.
  - A `req` still high in the cycle after `gnt` is a new request.
  - A `req` dropped before grant has no effect.
- **Operand stability:**
  - Only one operation is in flight.
  - `core_x`, `core_y` and `core_func` must not change between ISSUE and DONE.
  - Requester operand changes after the IDLE sample are ignored.
- **Reset:**
  - Outputs: all cleared to 0.
  - State and counter: state = IDLE, `ptr` = 0.
  - Core drive: `core_*` outputs = 0.
  - An in-flight operation is discarded. No `out_valid` is ever produced for it.
- **Unsupported `func` values:** forwarded unchanged; the scheduler does not validate them.

## Timing
- Request sampled at edge E0 (state IDLE).
- `gnt` and `core_st` are high in cycle 1, after E0. All outputs are registered.
- WAIT occupies cycles 2..`LATENCY`+1.
- `core_result` is sampled at edge E(`LATENCY`+1).
- `out_valid` is high in cycle `LATENCY`+2 and returns to 0 the next cycle.
- The next request can be sampled at E(`LATENCY`+3), so throughput is 1 op per `LATENCY`+3 cycles.
- Arrivals during ISSUE, WAIT or DONE wait in IDLE; arbitration happens only there.
- With all requesters continuously requesting, grants rotate 0,1,2,3,0,…

## Test plan
- **Single ln request:**
  - Stimulus: `LATENCY`=16, requester 2, `func`=8, `x`=16'h6000.
  - Core pins: `core_x`=16'hA000, `core_y`=16'h2000, `core_func`=8.
  - Handshake timing: `gnt`=4'b0100 in cycle 1; `core_st` high exactly one cycle.
  - Result: core model returns 32'h0000_0CF6 → `out_result`=32'h0000_19EC, `out_id`=2, `out_valid` in cycle 18.
- **Pass-through:**
  - Stimulus: requester 0, `func`=3, `x`=16'h1234, `y`=16'h0F00.
  - Required: core pins equal the inputs; `out_result` = `core_result` unshifted.
- **Fairness:**
  - Stimulus: `req`=4'b1111 held for 8 operations.
  - Required: grant order 0,1,2,3,0,1,2,3; exactly one `gnt` bit per operation.
  - Required: operations separated by exactly `LATENCY`+3 cycles.
- **Late arrival:**
  - Stimulus: requester 3 asserts during WAIT of requester 1's operation.
  - Required: no `gnt` to requester 3 until after requester 1's DONE; requester 3 is granted next.
  - Required: `core_x` stays stable throughout requester 1's operation.
- **Reset mid-operation:**
  - Stimulus: `rst` high for one cycle at WAIT counter = 5.
  - Required: the next cycle shows all outputs 0 and state IDLE, with no `out_valid` for the aborted operation.
  - Required: after reset, `req`=4'b1010 grants requester 1 first (`ptr`=0).
